gray_burst_sched: RTL and testbench
===================================

// Module: gray_burst_sched
// PURPOSE
//  Round-robin scheduler sharing one gray-coded address sequencer between two requesters.
//  Each grant loads a binary base and length, then streams base..base+len as gray codes.
//  The stream drives a RAM/CDC pointer port through a valid/ready handshake.
//  Sits between requester logic and gray-address consumers such as async FIFOs and pointer RAMs.
// PARAMETERS
//  SIZE   8  address width in bits; gray address width equals SIZE
//  LEN_W  4  burst length field width; beats = req_len+1 (1..2^LEN_W)
// PORTS
//  clk         in   1       clock, rising edge
//  nreset      in   1       asynchronous reset, active-low
//  req         in   2       burst request per requester; held high until its gnt pulse
//  req_base0   in   SIZE    requester 0 start address (binary)
//  req_base1   in   SIZE    requester 1 start address (binary)
//  req_len0    in   LEN_W   requester 0 beats-1
//  req_len1    in   LEN_W   requester 1 beats-1
//  abort       in   1       synchronous burst cancel
//  gnt         out  2       one-cycle pulse; base/len of granted requester latched this cycle
//  owner       out  1       index of requester owning the current/last burst
//  busy        out  1       high in RUN
//  addr_gray   out  SIZE    current address, gray = b ^ (b>>1)
//  addr_valid  out  1       addr_gray valid
//  addr_last   out  1       current beat is final beat of burst
//  addr_ready  in   1       consumer accepts beat when addr_valid & addr_ready
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, owner=0, busy=0, addr_gray=0, addr_valid=0, addr_last=0, rr pointer=0.
//  States: IDLE, RUN.
//  IDLE, req!=0 -> pulse gnt for the winner, latch base/len, set owner; next cycle RUN.
//  Arbitration: round-robin. Requester owner+1 has priority, then owner.
//    After reset requester 0 has priority. Single request always wins.
//  RUN: addr_valid=1. Binary index b starts at base.
//    addr_gray=gray(b) is registered and changes only on a handshake.
//    Handshake: b <= b+1 mod 2^SIZE (wraps, no saturation), remaining count decrements.
//    addr_last=1 when remaining==0.
//    Handshake on the last beat ends the burst (see CONFIGURATION for the next state).
//  Latency: gnt cycle -> first addr_valid on the next cycle (1 cycle).
//    Without handshake stall, one beat per cycle.
//  Stall: addr_ready=0 holds addr_gray/addr_last/addr_valid stable.
//  abort in RUN: next cycle IDLE, addr_valid=0, addr_last=0.
//    A handshake in the abort cycle is still counted. abort in IDLE is ignored.
//  abort and req in the same IDLE cycle: grant proceeds.
//  Requests arriving during RUN wait. gnt is never asserted in RUN except per B2B below.
//  req_len=0: single beat with addr_last=1.
//    req_len=all-ones: 2^LEN_W beats, count width LEN_W (no overflow).
//  Async reset mid-burst: all outputs to reset values immediately, burst discarded.
//  Reset release does not regrant: a requester still asserting req is granted in normal IDLE order.
//  gnt is never two-hot. addr_gray differs by exactly one bit between consecutive beats.
// CONFIGURATION
//  GRAY_SCHED_B2B_EN defined:
//    Last-beat handshake with req!=0 grants in that same cycle (gnt pulse).
//    State stays RUN; the new burst's first beat is valid on the next cycle, with no bubble.
//  GRAY_SCHED_B2B_EN undefined:
//    Last-beat handshake always returns to IDLE.
//    At least one cycle with addr_valid=0 separates bursts.
// TESTING
//  T1 req=01, base0=0x05, len0=3, ready=1:
//     gnt=01; beats 0x07,0x05,0x04,0x0C; addr_last on 0x0C; then IDLE.
//  T2 wrap: base0=0xFE, len0=2 -> beats 0x81,0x80,0x00; addr_last on 0x00.
//  T3 req=11 held, len=0 each:
//     grants alternate 01,10,01,...; owner toggles; no requester starved.
//  T4 stall: ready=0 for 3 cycles mid-burst -> addr_gray/addr_last unchanged; beat count intact.
//  T5 abort on beat 2 of len=7 -> addr_valid=0 next cycle; busy=0.
//     Pending req1 granted from IDLE.
//  T6 nreset low mid-burst -> all outputs 0 asynchronously.
//     After release with req=10: gnt=10; with B2B_EN, back-to-back bursts show no valid gap.

Source files
------------

// File: rtl/gray_burst_sched_if.sv
// Requester/consumer bundle for gray_burst_sched.
// The scheduler uses the slave modport; requester/consumer logic uses master.
interface gray_burst_sched_if #(
    parameter int SIZE  = 8,
    parameter int LEN_W = 4
);
    logic [1:0]       req;
    logic [SIZE-1:0]  req_base0;
    logic [SIZE-1:0]  req_base1;
    logic [LEN_W-1:0] req_len0;
    logic [LEN_W-1:0] req_len1;
    logic             abort;
    logic [1:0]       gnt;
    logic             owner;
    logic             busy;
    logic [SIZE-1:0]  addr_gray;
    logic             addr_valid;
    logic             addr_last;
    logic             addr_ready;

    modport master (
        output req, req_base0, req_base1, req_len0, req_len1, abort, addr_ready,
        input  gnt, owner, busy, addr_gray, addr_valid, addr_last
    );

    modport slave (
        input  req, req_base0, req_base1, req_len0, req_len1, abort, addr_ready,
        output gnt, owner, busy, addr_gray, addr_valid, addr_last
    );
endinterface

// File: rtl/gray_burst_sched.sv
// gray_burst_sched: round-robin scheduler sharing one gray-coded address
// sequencer between two requesters. A grant latches a binary base and length;
// the burst then streams gray(base)..gray(base+len) over a valid/ready port.
// Optional feature macro GRAY_SCHED_B2B_EN: a last-beat handshake with a
// pending request grants in the same cycle so bursts run back-to-back.
module gray_burst_sched #(
    parameter int SIZE  = 8,
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              nreset,
    gray_burst_sched_if.slave bus
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [SIZE-1:0]  ONE_A = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] ONE_L = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SIZE-1:0]  r_bin;
    logic [SIZE-1:0]  r_gray;
    logic [LEN_W-1:0] r_rem;
    logic             r_last;
    logic             r_owner;
    logic             r_rr;

    logic             w_run;
    logic             w_hs;
    logic             w_last_hs;
    logic             w_win;
    logic             w_grant;
    logic [SIZE-1:0]  w_base;
    logic [LEN_W-1:0] w_len;
    logic [SIZE-1:0]  w_bin_inc;

    function automatic logic [SIZE-1:0] f_gray(input logic [SIZE-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign w_run     = (r_state == S_RUN);
    assign w_hs      = w_run & bus.addr_ready;
    assign w_last_hs = w_hs & (r_rem == '0);
    assign w_bin_inc = r_bin + ONE_A;

    // Arbitration: with both requesting, r_rr names the favoured requester
    // (reset favours 0, afterwards the one that did not win last).
    always_comb begin
        w_win  = (bus.req == 2'b11) ? r_rr : bus.req[1];
        w_base = w_win ? bus.req_base1 : bus.req_base0;
        w_len  = w_win ? bus.req_len1  : bus.req_len0;
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and grant decision; abort beats everything in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_hs) begin
`ifdef GRAY_SCHED_B2B_EN
                    if (bus.req != 2'b00) begin
                        w_grant     = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst datapath: load on grant, advance one address per handshake.
    // A handshake in an abort cycle still advances; the burst is dropped anyway.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_rem   <= '0;
            r_last  <= 1'b0;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
        end else if (w_grant) begin
            r_bin   <= w_base;
            r_gray  <= f_gray(w_base);
            r_rem   <= w_len;
            r_last  <= (w_len == '0);
            r_owner <= w_win;
            r_rr    <= ~w_win;
        end else if (w_hs) begin
            r_bin   <= w_bin_inc;
            r_gray  <= f_gray(w_bin_inc);
            r_rem   <= r_rem - ONE_L;
            r_last  <= (r_rem == ONE_L);
        end
    end

    // gnt is combinational in the grant cycle; held off while reset is asserted.
    assign bus.gnt        = (w_grant & nreset) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign bus.owner      = r_owner;
    assign bus.busy       = w_run;
    assign bus.addr_valid = w_run;
    assign bus.addr_gray  = r_gray;
    assign bus.addr_last  = r_last & w_run;

endmodule

// File: tb/tb_gray_burst_sched.sv
// Self-checking bench for gray_burst_sched: directed steps then random traffic,
// compared each cycle with a burst-queue reference model.
module tb_gray_burst_sched;
    localparam int SIZE  = 8;
    localparam int LEN_W = 4;

    logic clk    = 1'b0;
    logic nreset = 1'b0;

    gray_burst_sched_if #(.SIZE(SIZE), .LEN_W(LEN_W)) bus ();

    gray_burst_sched #(.SIZE(SIZE), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: running flag, queue of binary addresses still to send
    bit              m_run;
    int              m_prio;
    int              m_owner;
    logic [SIZE-1:0] m_q[$];
    logic [SIZE-1:0] obs_beats[$];

    function automatic logic [SIZE-1:0] gray(input logic [SIZE-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_prio  = 0;
        m_owner = 0;
        m_q.delete();
    endtask

    task automatic req_set(input int k, input logic [SIZE-1:0] base, input logic [LEN_W-1:0] len);
        bus.req[k] = 1'b1;
        if (k == 0) begin bus.req_base0 = base; bus.req_len0 = len; end
        else        begin bus.req_base1 = base; bus.req_len1 = len; end
    endtask

    // One clock: check at negedge, update model at posedge, drop granted reqs.
    task automatic cycle();
        int w;
        logic [1:0] eg;
        bit hs;
        logic [SIZE-1:0] a;
        logic [LEN_W-1:0] len;
        @(negedge clk);
        w  = (bus.req == 2'b11) ? m_prio : (bus.req[1] ? 1 : 0);
        hs = m_run && bus.addr_ready;
        eg = 2'b00;
        if (!m_run && bus.req != 2'b00) eg = (w == 1) ? 2'b10 : 2'b01;
`ifdef GRAY_SCHED_B2B_EN
        else if (hs && m_q.size() == 1 && !bus.abort && bus.req != 2'b00)
            eg = (w == 1) ? 2'b10 : 2'b01;
`endif
        chk("gnt",   bus.gnt, eg);
        chk("valid", bus.addr_valid, m_run);
        chk("busy",  bus.busy, m_run);
        chk("owner", bus.owner, m_owner);
        chk("last",  bus.addr_last, (m_run && m_q.size() == 1));
        if (m_run && m_q.size() > 0) chk("addr_gray", bus.addr_gray, gray(m_q[0]));
        if (bus.addr_valid && bus.addr_ready) obs_beats.push_back(bus.addr_gray);
        @(posedge clk);
        if (eg != 2'b00) begin
            m_owner = w;
            m_prio  = 1 - w;
            a   = (w == 1) ? bus.req_base1 : bus.req_base0;
            len = (w == 1) ? bus.req_len1  : bus.req_len0;
            m_q.delete();
            for (int i = 0; i <= int'(len); i++) begin
                m_q.push_back(a);
                a = a + 1'b1;
            end
            m_run = 1'b1;
        end else if (m_run) begin
            if (hs) void'(m_q.pop_front());
            if (bus.abort || m_q.size() == 0) begin
                m_run = 1'b0;
                m_q.delete();
            end
        end
        #1;
        if (eg[0]) bus.req[0] = 1'b0;
        if (eg[1]) bus.req[1] = 1'b0;
    endtask

    task automatic chk_beats(input string tag, input logic [SIZE-1:0] e0, input logic [SIZE-1:0] e1,
                             input logic [SIZE-1:0] e2, input logic [SIZE-1:0] e3, input int n);
        logic [SIZE-1:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, obs_beats.size(), n);
        for (int i = 0; i < n && i < obs_beats.size(); i++) chk(tag, obs_beats[i], e[i]);
    endtask

    initial begin
        bus.req = 2'b00; bus.req_base0 = '0; bus.req_base1 = '0;
        bus.req_len0 = '0; bus.req_len1 = '0; bus.abort = 1'b0; bus.addr_ready = 1'b1;
        model_reset();

        // reset state, with a request already pending
        bus.req = 2'b01;
        #12;
        chk("rst_gnt",   bus.gnt, 2'b00);
        chk("rst_owner", bus.owner, 1'b0);
        chk("rst_busy",  bus.busy, 1'b0);
        chk("rst_gray",  bus.addr_gray, 8'h00);
        chk("rst_valid", bus.addr_valid, 1'b0);
        chk("rst_last",  bus.addr_last, 1'b0);
        bus.req = 2'b00;
        @(posedge clk); #1;
        nreset = 1'b1;

        // T1: base 0x05, len 3
        obs_beats.delete();
        req_set(0, 8'h05, 4'd3);
        repeat (7) cycle();
        chk_beats("t1_beat", 8'h07, 8'h05, 8'h04, 8'h0C, 4);

        // T2: address wrap
        obs_beats.delete();
        req_set(0, 8'hFE, 4'd2);
        repeat (6) cycle();
        chk_beats("t2_beat", 8'h81, 8'h80, 8'h00, 8'h00, 3);

        // T3: both requesters held, single-beat bursts
        for (int i = 0; i < 14; i++) begin
            if (!bus.req[0]) req_set(0, 8'(8'h20 + i), 4'd0);
            if (!bus.req[1]) req_set(1, 8'(8'hA0 + i), 4'd0);
            cycle();
        end
        bus.req = 2'b00;
        repeat (3) cycle();

        // T4: stall mid-burst
        req_set(0, 8'h30, 4'd5);
        repeat (3) cycle();
        bus.addr_ready = 1'b0;
        repeat (3) cycle();
        bus.addr_ready = 1'b1;
        repeat (6) cycle();

        // T5: abort on beat 2 of len 7, req1 pending
        req_set(0, 8'h40, 4'd7);
        repeat (3) cycle();
        req_set(1, 8'h80, 4'd2);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        repeat (6) cycle();

        // full-length burst (len all ones)
        req_set(1, 8'hF8, 4'hF);
        repeat (19) cycle();

        // T6: async reset mid-burst
        req_set(0, 8'h10, 4'd7);
        repeat (3) cycle();
        #3 nreset = 1'b0;
        #1;
        chk("t6_gnt",   bus.gnt, 2'b00);
        chk("t6_busy",  bus.busy, 1'b0);
        chk("t6_valid", bus.addr_valid, 1'b0);
        chk("t6_last",  bus.addr_last, 1'b0);
        chk("t6_gray",  bus.addr_gray, 8'h00);
        chk("t6_owner", bus.owner, 1'b0);
        model_reset();
        bus.req = 2'b00;
        req_set(1, 8'h55, 4'd1);
        @(posedge clk); #2;
        nreset = 1'b1;
        cycle();
        req_set(0, 8'h66, 4'd1);
        repeat (6) cycle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++)
                if (!bus.req[k] && $urandom_range(0, 3) == 0)
                    req_set(k, 8'($urandom), 4'($urandom));
            bus.addr_ready = ($urandom_range(0, 3) != 0);
            bus.abort      = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
